// File: rtl/dmem_ctrl.sv
// Data-memory target behind the dbus decoder: word SRAM, wait-state sequencer,
// byte-masked stores and abort handling. Optional range check: DMEM_RANGE_CHK_EN.
module dmem_ctrl #(
    parameter int DEPTH_WORDS = 4096,
    parameter int WAIT_STATES = 1,
    parameter int WINDOW_BITS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dmem_sel_i,
    input  logic        req_i,
    input  logic        w_en_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] w_data_i,
    input  logic [3:0]  sel_byte_i,
    output logic [31:0] r_data_o,
    output logic        ack_o,
    output logic        err_o,
    output logic        busy_o
);

    localparam int IDX_BITS = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WS = WAIT_STATES[3:0];

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t state;
    logic [3:0] cnt;

    logic [IDX_BITS-1:0] cap_idx;
    logic [31:0]         cap_wdata;
    logic [3:0]          cap_sel;
    logic                cap_we;
    logic                cap_oor;

    logic [31:0] mem [0:DEPTH_WORDS-1];

    logic                window_nz;
    logic                in_oor;
    logic                hold;
    logic                start;
    logic                go_resp;
    logic [IDX_BITS-1:0] acc_idx;
    logic [31:0]         acc_wdata;
    logic [3:0]          acc_sel;
    logic                acc_we;
    logic                acc_oor;
    logic                unused_sink;

    // Upper window bits between the word index and the window top.
    generate
        if (WINDOW_BITS > IDX_BITS + 2) begin : g_window
            assign window_nz = |addr_i[WINDOW_BITS-1:IDX_BITS+2];
        end else begin : g_no_window
            assign window_nz = 1'b0;
        end
    endgenerate

`ifdef DMEM_RANGE_CHK_EN
    assign in_oor = window_nz;
`else
    assign in_oor = 1'b0;
`endif

    assign unused_sink = ^{addr_i[31:IDX_BITS+2], addr_i[1:0], window_nz};

    // With zero wait states the access happens on the capture edge itself,
    // so the access fields come straight from the inputs in IDLE.
    always_comb begin
        hold      = dmem_sel_i & req_i;
        start     = (state == ST_IDLE) && hold;
        go_resp   = (start && (WS == 4'd0)) ||
                    ((state == ST_WAIT) && hold && (cnt == 4'd1));
        acc_idx   = cap_idx;
        acc_wdata = cap_wdata;
        acc_sel   = cap_sel;
        acc_we    = cap_we;
        acc_oor   = cap_oor;
        if (state == ST_IDLE) begin
            acc_idx   = addr_i[IDX_BITS+1:2];
            acc_wdata = w_data_i;
            acc_sel   = sel_byte_i;
            acc_we    = w_en_i;
            acc_oor   = in_oor;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            cap_idx   <= '0;
            cap_wdata <= 32'd0;
            cap_sel   <= 4'd0;
            cap_we    <= 1'b0;
            cap_oor   <= 1'b0;
            r_data_o  <= 32'd0;
            ack_o     <= 1'b0;
            err_o     <= 1'b0;
            busy_o    <= 1'b0;
        end else begin
            ack_o <= 1'b0;
            err_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cap_idx   <= addr_i[IDX_BITS+1:2];
                        cap_wdata <= w_data_i;
                        cap_sel   <= sel_byte_i;
                        cap_we    <= w_en_i;
                        cap_oor   <= in_oor;
                        cnt       <= WS;
                        busy_o    <= 1'b1;
                        state     <= (WS == 4'd0) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!hold) begin
                        state  <= ST_IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            state <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
            if (go_resp) begin
                ack_o <= 1'b1;
                err_o <= acc_oor;
                if (acc_oor) begin
                    r_data_o <= 32'd0;
                end else if (!acc_we) begin
                    r_data_o <= mem[acc_idx];
                end
            end
        end
    end

    // Memory contents survive reset; writes commit on the edge into RESP.
    always_ff @(posedge clk) begin
        if (!rst && go_resp && acc_we && !acc_oor) begin
            for (int n = 0; n < 4; n++) begin
                if (acc_sel[n]) begin
                    mem[acc_idx][8*n +: 8] <= acc_wdata[8*n +: 8];
                end
            end
        end
    end

endmodule
